// File: rtl/ecc_secded_page_decoder_if.sv
// ecc_secded_page_decoder_if
//   Interface for the page SECDED decoder. It carries the input word stream
//   (in_valid/in_ready/in_data/in_last/in_code) and the corrected output
//   stream (out_valid/out_ready/out_data/out_last/out_status).
//   The width of in_code (P+1) is derived from DATA_W and DEPTH in the same
//   way as inside the decoder.
//   modport slave  : the decoder side
//   modport master : the producer/consumer side
interface ecc_secded_page_decoder_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
);

  // Smallest P with 2^P >= n + P + 1.
  function automatic int calc_p(input int n);
    int p;
    p = 0;
    for (int i = 1; i < 31; i++) begin
      if (p == 0 && (1 << i) >= n + i + 1) p = i;
    end
    return p;
  endfunction

  localparam int P = calc_p(DATA_W * DEPTH);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic [P:0]        in_code;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic [1:0]        out_status;

  modport slave (
    input  in_valid, in_data, in_last, in_code, out_ready,
    output in_ready, out_valid, out_data, out_last, out_status
  );

  modport master (
    output in_valid, in_data, in_last, in_code, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_status
  );

endinterface

// File: rtl/ecc_secded_page_decoder.sv
// ecc_secded_page_decoder
//   SECDED (Hamming + overall parity) decoder over one page of up to DEPTH
//   words of DATA_W bits. Words are buffered while the syndrome and parity
//   are accumulated one word per beat; the page is decoded in one cycle at
//   its end and then streamed out, corrected, under valid/ready.
//   Ports:
//     clk, rst    clock and synchronous active-high reset
//     bus         slave side of ecc_secded_page_decoder_if (in/out streams)
//     corr_cnt    saturating count of pages with status 01
//     uncorr_cnt  saturating count of pages with status 10
module ecc_secded_page_decoder #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  ecc_secded_page_decoder_if.slave bus,
  output logic [CNT_W-1:0]         corr_cnt,
  output logic [CNT_W-1:0]         uncorr_cnt
);

  // Smallest P with 2^P >= n + P + 1.
  function automatic int calc_p(input int n);
    int p;
    p = 0;
    for (int i = 1; i < 31; i++) begin
      if (p == 0 && (1 << i) >= n + i + 1) p = i;
    end
    return p;
  endfunction

  // Codeword position of data bit d: the d-th integer >= 3 that is not a
  // power of two. Every power of two at or below the running value pushes
  // the position up by one.
  function automatic int pos_of(input int d);
    int p;
    p = d + 1;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) <= p) p = p + 1;
    end
    return p;
  endfunction

  localparam int N  = DATA_W * DEPTH;
  localparam int P  = calc_p(N);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [P-1:0] MAX_POS = P'(pos_of(N - 1));

  typedef enum logic [1:0] {FILL, DECODE, DRAIN} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     rcv;
  logic [AW-1:0]     idx;
  logic [P-1:0]      syn_acc;
  logic              par_acc;
  logic [P:0]        code_q;
  logic [DATA_W-1:0] buffer [DEPTH];
  logic              ready_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_last_q;
  logic [1:0]        status_q;
  logic [CNT_W-1:0]  corr_q;
  logic [CNT_W-1:0]  uncorr_q;

  logic              accept;
  logic              page_end;
  logic [P-1:0]      word_syn;
  logic [P-1:0]      syn;
  logic              par;
  logic [P-1:0]      msb;
  logic [P-1:0]      dlin;
  logic [P-1:0]      fix_word;
  logic [BW-1:0]     fix_bit;
  logic [DATA_W-1:0] fix_mask;
  logic              fix_en;
  logic [1:0]        status_n;

  assign accept   = (state == FILL) && ready_q && bus.in_valid;
  assign page_end = accept && (bus.in_last || cnt == CW'(DEPTH - 1));

  // Syndrome contribution of the incoming word: XOR of the codeword
  // positions of its set bits. Positions depend on which word slot is
  // being filled, so each slot has its own constant position set.
  always_comb begin
    word_syn = '0;
    for (int w = 0; w < DEPTH; w++) begin
      for (int b = 0; b < DATA_W; b++) begin
        if (cnt[AW-1:0] == AW'(w) && bus.in_data[b])
          word_syn = word_syn ^ P'(pos_of(w * DATA_W + b));
      end
    end
  end

  // Page classification. A non-power-of-two syndrome s >= 3 maps back to
  // data bit s - floor(log2 s) - 2; the word it lands in must have been
  // received for the error to be correctable.
  always_comb begin
    syn = syn_acc ^ code_q[P-1:0];
    par = par_acc ^ (^code_q[P-1:0]) ^ code_q[P];
    msb = '0;
    for (int i = 0; i < P; i++) begin
      if (syn[i]) msb = P'(i);
    end
    dlin     = syn - msb - P'(2);
    fix_word = dlin / P'(DATA_W);
    fix_bit  = BW'(dlin % P'(DATA_W));
    fix_mask = DATA_W'(1) << fix_bit;
    fix_en   = 1'b0;
    status_n = 2'b00;
    if (syn == '0) begin
      status_n = par ? 2'b01 : 2'b00;
    end else if (!par) begin
      status_n = 2'b10;
    end else if ((syn & (syn - P'(1))) == '0) begin
      status_n = 2'b01;
    end else if (syn > MAX_POS || fix_word >= P'(rcv)) begin
      status_n = 2'b10;
    end else begin
      status_n = 2'b01;
      fix_en   = 1'b1;
    end
  end

  // Main FSM: FILL buffers and accumulates, DECODE applies the correction
  // in place and loads the first output word, DRAIN streams the buffer.
  // The correction is written into the buffer during DECODE, so word 0 is
  // patched on the fly while every later word is read already corrected.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FILL;
      cnt         <= '0;
      rcv         <= '0;
      idx         <= '0;
      syn_acc     <= '0;
      par_acc     <= 1'b0;
      code_q      <= '0;
      ready_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      status_q    <= 2'b00;
      corr_q      <= '0;
      uncorr_q    <= '0;
      for (int i = 0; i < DEPTH; i++) buffer[i] <= '0;
    end else begin
      case (state)
        FILL: begin
          ready_q <= 1'b1;
          if (accept) begin
            buffer[cnt[AW-1:0]] <= bus.in_data;
            syn_acc             <= syn_acc ^ word_syn;
            par_acc             <= par_acc ^ (^bus.in_data);
            cnt                 <= cnt + CW'(1);
            if (page_end) begin
              code_q  <= bus.in_code;
              rcv     <= cnt + CW'(1);
              ready_q <= 1'b0;
              state   <= DECODE;
            end
          end
        end
        DECODE: begin
          status_q <= status_n;
          if (status_n == 2'b01 && corr_q != '1) corr_q <= corr_q + CNT_W'(1);
          if (status_n == 2'b10 && uncorr_q != '1) uncorr_q <= uncorr_q + CNT_W'(1);
          if (fix_en)
            buffer[fix_word[AW-1:0]][fix_bit] <= ~buffer[fix_word[AW-1:0]][fix_bit];
          out_data_q  <= buffer[0] ^ ((fix_en && fix_word == '0) ? fix_mask : '0);
          out_valid_q <= 1'b1;
          out_last_q  <= (rcv == CW'(1));
          idx         <= '0;
          state       <= DRAIN;
        end
        DRAIN: begin
          if (bus.out_ready) begin
            if (out_last_q) begin
              state       <= FILL;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              out_data_q  <= '0;
              ready_q     <= 1'b1;
              cnt         <= '0;
              syn_acc     <= '0;
              par_acc     <= 1'b0;
              for (int i = 0; i < DEPTH; i++) buffer[i] <= '0;
            end else begin
              idx        <= idx + AW'(1);
              out_data_q <= buffer[idx + AW'(1)];
              out_last_q <= ({1'b0, idx} + CW'(2)) == rcv;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  assign bus.in_ready   = ready_q & ~rst;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_last   = out_last_q;
  assign bus.out_status = status_q;
  assign corr_cnt       = corr_q;
  assign uncorr_cnt     = uncorr_q;

endmodule

// File: tb/tb_ecc_secded_page_decoder.sv
// tb_ecc_secded_page_decoder
//   Self-checking bench for ecc_secded_page_decoder. A reference model
//   builds the data-bit position table by scanning integers, encodes pages,
//   injects errors and classifies each page by searching that table, then
//   compares every output word, status, latency and counter value.
//   The counters are made 4 bits wide here so saturation is reachable.
module tb_ecc_secded_page_decoder;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 4;
  localparam int P      = 8;
  localparam int N      = DATA_W * DEPTH;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  logic [CNT_W-1:0] corr_cnt;
  logic [CNT_W-1:0] uncorr_cnt;

  always #5 clk = ~clk;

  ecc_secded_page_decoder_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  ecc_secded_page_decoder #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .corr_cnt   (corr_cnt),
    .uncorr_cnt (uncorr_cnt)
  );

  int tests    = 0;
  int failures = 0;
  int pos_list [N];
  logic [DATA_W-1:0] page      [DEPTH];
  logic [DATA_W-1:0] exp_words [DEPTH];
  logic [1:0] exp_status;
  int exp_corr   = 0;
  int exp_uncorr = 0;

  // Single comparison point: counts and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  // Data-bit positions: successive integers from 3, skipping powers of two.
  task automatic buildPositions();
    int v;
    v = 3;
    for (int d = 0; d < N; d++) begin
      while (is_pow2(v)) v++;
      pos_list[d] = v;
      v++;
    end
  endtask

  // Clean check code for the first n words of page.
  function automatic logic [P:0] encode(input int n);
    int s;
    bit q;
    logic [P:0] c;
    s = 0;
    q = 1'b0;
    for (int w = 0; w < n; w++)
      for (int b = 0; b < DATA_W; b++)
        if (page[w][b]) begin
          s = s ^ pos_list[w * DATA_W + b];
          q = ~q;
        end
    c[P-1:0] = s[P-1:0];
    c[P]     = q ^ (^s[P-1:0]);
    return c;
  endfunction

  // Expected words, status and counters for the page about to be sent.
  task automatic modelDecode(input int n, input logic [P:0] code);
    int s;
    bit q;
    int found;
    s = 0;
    q = 1'b0;
    for (int w = 0; w < DEPTH; w++) exp_words[w] = (w < n) ? page[w] : '0;
    for (int w = 0; w < n; w++)
      for (int b = 0; b < DATA_W; b++)
        if (page[w][b]) begin
          s = s ^ pos_list[w * DATA_W + b];
          q = ~q;
        end
    s = s ^ int'(code[P-1:0]);
    q = q ^ (^code[P-1:0]) ^ code[P];
    if (s == 0) exp_status = q ? 2'b01 : 2'b00;
    else if (!q) exp_status = 2'b10;
    else if (is_pow2(s)) exp_status = 2'b01;
    else begin
      found = -1;
      for (int d = 0; d < N; d++) if (pos_list[d] == s) found = d;
      if (found >= 0 && (found / DATA_W) < n) begin
        exp_words[found / DATA_W][found % DATA_W] = ~exp_words[found / DATA_W][found % DATA_W];
        exp_status = 2'b01;
      end else begin
        exp_status = 2'b10;
      end
    end
    if (exp_status == 2'b01 && exp_corr < CNT_MAX) exp_corr++;
    if (exp_status == 2'b10 && exp_uncorr < CNT_MAX) exp_uncorr++;
  endtask

  // Sends n words; in_code carries noise except on the ending beat.
  // Ends on the negedge where the first output word should be visible.
  task automatic applyStimulus(input int n, input bit use_last, input logic [P:0] code);
    int k;
    int guard;
    k = 0;
    guard = 0;
    while (k < n && guard < 100) begin
      @(negedge clk);
      checkOutput("fill_out_valid", bus.out_valid, 0);
      bus.in_valid = 1'b1;
      bus.in_data  = page[k];
      bus.in_last  = use_last && (k == n - 1);
      bus.in_code  = (k == n - 1) ? code : (P+1)'($urandom);
      if (bus.in_ready) k++;
      guard++;
    end
    if (k < n) checkOutput("fill_timeout", k, n);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = DATA_W'($urandom);
    checkOutput("lat_decode_valid", bus.out_valid, 0);
    checkOutput("lat_in_ready", bus.in_ready, 0);
    @(negedge clk);
    checkOutput("lat_first_valid", bus.out_valid, 1);
  endtask

  // Drains up to 'take' words. mode 0: always ready, 1: random ready,
  // 2: ready held low for 3 cycles while word 2 is presented.
  task automatic collectPage(input int n, input int mode, input int take);
    int k;
    int guard;
    int stall;
    bit rdy;
    bit broke;
    k = 0;
    guard = 0;
    stall = 0;
    broke = 1'b0;
    while (k < take && guard < 500 && !broke) begin
      if (bus.out_valid) begin
        checkOutput("out_data", bus.out_data, exp_words[k]);
        checkOutput("out_last", bus.out_last, (k == n - 1));
        checkOutput("out_status", bus.out_status, exp_status);
        checkOutput("drain_in_ready", bus.in_ready, 0);
        if (mode == 1) rdy = ($urandom_range(0, 2) != 0);
        else if (mode == 2 && k == 2 && stall < 3) begin
          rdy = 1'b0;
          stall++;
        end else rdy = 1'b1;
        bus.out_ready = rdy;
        if (rdy) k++;
        @(negedge clk);
      end else begin
        checkOutput("drain_out_valid", bus.out_valid, 1);
        broke = 1'b1;
      end
      guard++;
    end
    if (k < take && !broke) checkOutput("drain_timeout", k, take);
    bus.out_ready = 1'b0;
    if (take == n) begin
      checkOutput("end_out_valid", bus.out_valid, 0);
      checkOutput("end_in_ready", bus.in_ready, 1);
      checkOutput("corr_cnt", corr_cnt, exp_corr);
      checkOutput("uncorr_cnt", uncorr_cnt, exp_uncorr);
    end
  endtask

  task automatic runPage(input int n, input bit use_last, input logic [P:0] code, input int mode);
    modelDecode(n, code);
    applyStimulus(n, use_last, code);
    collectPage(n, mode, n);
  endtask

  task automatic clearPage();
    for (int w = 0; w < DEPTH; w++) page[w] = '0;
  endtask

  // Random page with a random kind of injected error.
  task automatic randomPage(input int mode);
    int n;
    int kind;
    int d1;
    int d2;
    bit use_last;
    logic [P:0] code;
    clearPage();
    n = $urandom_range(1, DEPTH);
    use_last = (n < DEPTH) ? 1'b1 : bit'($urandom_range(0, 1));
    for (int w = 0; w < n; w++) page[w] = DATA_W'($urandom);
    code = encode(n);
    kind = $urandom_range(0, 5);
    case (kind)
      1: begin
        d1 = $urandom_range(0, n * DATA_W - 1);
        page[d1 / DATA_W][d1 % DATA_W] = ~page[d1 / DATA_W][d1 % DATA_W];
      end
      2: code[$urandom_range(0, P - 1)] = ~code[$urandom_range(0, P - 1)];
      3: code[P] = ~code[P];
      4: begin
        d1 = $urandom_range(0, n * DATA_W - 1);
        d2 = (d1 + $urandom_range(1, n * DATA_W - 1)) % (n * DATA_W);
        if (n * DATA_W < 2) d2 = d1;
        page[d1 / DATA_W][d1 % DATA_W] = ~page[d1 / DATA_W][d1 % DATA_W];
        page[d2 / DATA_W][d2 % DATA_W] = ~page[d2 / DATA_W][d2 % DATA_W];
      end
      5: code = (P+1)'($urandom);
      default: ;
    endcase
    runPage(n, use_last, code, mode);
  endtask

  initial begin
    logic [P:0] code;
    buildPositions();
    clearPage();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.in_code   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_out_data", bus.out_data, 0);
    checkOutput("rst_out_last", bus.out_last, 0);
    checkOutput("rst_out_status", bus.out_status, 0);
    checkOutput("rst_corr", corr_cnt, 0);
    checkOutput("rst_uncorr", uncorr_cnt, 0);
    checkOutput("rst_in_ready", bus.in_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_in_ready", bus.in_ready, 1);

    // Full zero page, clean.
    runPage(DEPTH, 1'b0, '0, 0);

    // Single data-bit errors at the first and the last data bit.
    clearPage();
    page[0] = 16'h0001;
    runPage(DEPTH, 1'b1, '0, 0);
    checkOutput("t2_corr_cnt", corr_cnt, 1);
    clearPage();
    page[7] = 16'h8000;
    runPage(DEPTH, 1'b1, '0, 1);

    // Double error, check-bit error, overall-parity error.
    clearPage();
    page[0] = 16'h0003;
    runPage(DEPTH, 1'b1, '0, 0);
    checkOutput("t3_uncorr_cnt", uncorr_cnt, 1);
    clearPage();
    runPage(DEPTH, 1'b1, 9'h001, 0);
    runPage(DEPTH, 1'b1, 9'h100, 0);

    // Short page, then a short page whose syndrome points into word 5.
    clearPage();
    page[0] = 16'h1234;
    page[1] = 16'hbeef;
    page[2] = 16'h0f0f;
    runPage(3, 1'b1, encode(3), 1);
    clearPage();
    code[P-1:0] = pos_list[5 * DATA_W][P-1:0];
    code[P]     = ~(^code[P-1:0]);
    runPage(3, 1'b1, code, 0);

    // Backpressure at word 2.
    clearPage();
    for (int w = 0; w < DEPTH; w++) page[w] = DATA_W'($urandom);
    runPage(DEPTH, 1'b1, encode(DEPTH), 2);

    // Drive enough corrected pages to saturate corr_cnt.
    clearPage();
    for (int i = 0; i <= CNT_MAX; i++) runPage(1, 1'b1, 9'h001, 0);
    checkOutput("sat_corr_cnt", corr_cnt, CNT_MAX);

    // Reset in the middle of draining.
    clearPage();
    for (int w = 0; w < DEPTH; w++) page[w] = DATA_W'($urandom);
    code = encode(DEPTH);
    code[0] = ~code[0];
    modelDecode(DEPTH, code);
    applyStimulus(DEPTH, 1'b1, code);
    collectPage(DEPTH, 0, 2);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_out_valid", bus.out_valid, 0);
    checkOutput("mid_rst_corr", corr_cnt, 0);
    checkOutput("mid_rst_uncorr", uncorr_cnt, 0);
    checkOutput("mid_rst_in_ready", bus.in_ready, 0);
    rst = 1'b0;
    exp_corr   = 0;
    exp_uncorr = 0;
    @(negedge clk);
    checkOutput("mid_rst_in_ready_up", bus.in_ready, 1);
    checkOutput("mid_rst_still_idle", bus.out_valid, 0);
    clearPage();
    for (int w = 0; w < DEPTH; w++) page[w] = DATA_W'($urandom);
    runPage(DEPTH, 1'b1, encode(DEPTH), 0);

    // Randomized pages.
    for (int i = 0; i < 40; i++) randomPage(i % 2);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
